// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Buffers 8-bit unsigned audio samples from the ROM player in a small FIFO
//   and serialises them as a left-justified, I2S-style stream (bclk, lrclk,
//   sdata) for the board codec. All serial timing comes from clk through an
//   internal divider.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   sample_in    unsigned sample (0x80 = midscale)
//   sample_valid sample_in is valid; pushed when sample_ready is also high
//   sample_ready FIFO can accept a sample
//   bclk         serial bit clock, period 2*BCLK_DIV clk cycles
//   lrclk        channel select: 0 = left, 1 = right
//   sdata        serial data, MSB first, changes on bclk falling edge
//   underrun     one-cycle pulse when a slot load finds the FIFO empty
//   fifo_level   current FIFO occupancy
//
// Build option:
//   AUDIO_I2S_TX_STEREO_EN  when defined, a sample is popped at each slot start
//                           (left, right, left, ...). When undefined the same
//                           sample is sent in both slots (one pop per frame).

module audio_i2s_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_BITS = 16,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = $clog2(2 * FRAME_BITS);
    localparam int DVW = $clog2(BCLK_DIV);

    localparam logic [LW-1:0]  FULL     = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0]  LAST_BIT = BW'(2 * FRAME_BITS - 1);
    localparam logic [BW-1:0]  HALF_BIT = BW'(FRAME_BITS);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(BCLK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN_FLIP = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          count;

    logic [DVW-1:0]         div_cnt;
    logic [BW-1:0]          bit_cnt;
    logic                   bclk_r;
    logic [FRAME_BITS-1:0]  shreg;
    logic [DATA_WIDTH-1:0]  hold;
    logic                   underrun_r;

    logic                   push;
    logic                   pop;
    logic                   bit_tick;
    logic [BW-1:0]          next_bit;
    logic                   slot_start;
    logic                   mono_reload;
    logic                   load;
    logic [DATA_WIDTH-1:0]  load_word;
    logic                   underrun_set;
    logic [DATA_WIDTH-1:0]  head_conv;

    assign sample_ready = (count != FULL);
    assign fifo_level   = count;
    assign bclk         = bclk_r;
    assign lrclk        = (bit_cnt >= HALF_BIT);
    assign sdata        = shreg[FRAME_BITS-1];
    assign underrun     = underrun_r;

    // Unsigned to two's complement: flipping the MSB moves 0x80 to zero.
    assign head_conv = mem[rd_ptr] ^ SIGN_FLIP;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Once running, the link keeps framing forever; underruns send silence.
    always_comb begin
        state_next = state;
        if (state == IDLE && count != '0) state_next = RUN;
    end

    always_comb begin
        push         = sample_valid && sample_ready;
        pop          = 1'b0;
        bit_tick     = 1'b0;
        slot_start   = 1'b0;
        mono_reload  = 1'b0;
        load         = 1'b0;
        load_word    = hold;
        underrun_set = 1'b0;
        next_bit     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    load_word = head_conv;
                end
            end
            RUN: begin
                // Bits advance on the bclk falling edge so data is stable
                // for the codec's rising-edge sample.
                bit_tick = (div_cnt == DIV_LAST) && bclk_r;
`ifdef AUDIO_I2S_TX_STEREO_EN
                slot_start  = bit_tick && (next_bit == '0 || next_bit == HALF_BIT);
`else
                slot_start  = bit_tick && (next_bit == '0);
                mono_reload = bit_tick && (next_bit == HALF_BIT);
`endif
                if (slot_start) begin
                    load = 1'b1;
                    if (count != '0) begin
                        pop       = 1'b1;
                        load_word = head_conv;
                    end else begin
                        load_word    = '0;
                        underrun_set = 1'b1;
                    end
                end else if (mono_reload) begin
                    load      = 1'b1;
                    load_word = hold;
                end
            end
            default: ;
        endcase
    end

    // Sample storage is not reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk_r     <= 1'b0;
            shreg      <= '0;
            hold       <= '0;
            underrun_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            underrun_r <= underrun_set;

            if (state == IDLE) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                bclk_r  <= 1'b0;
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    bclk_r  <= ~bclk_r;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (bit_tick) bit_cnt <= next_bit;
            end

            // The sample is left-justified; the low slot bits shift in as 0.
            if (load) begin
                shreg <= FRAME_BITS'(load_word) << (FRAME_BITS - DATA_WIDTH);
                hold  <= load_word;
            end else if (bit_tick) begin
                shreg <= shreg << 1;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx
//   Self-checking bench for audio_i2s_tx at default parameters (mono build).
//   Accepted samples enter a scoreboard queue of expected slot words; frame
//   starts pop it. A monitor sampling 1 ns after each rising edge compares
//   bclk/lrclk/sdata/underrun/fifo_level/sample_ready every cycle.

module tb_audio_i2s_tx;

    typedef struct {
        logic [7:0]  sample;
        logic [15:0] slot;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       bclk;
    logic       lrclk;
    logic       sdata;
    logic       underrun;
    logic [2:0] fifo_level;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] q[$];
    logic [15:0] cur_exp;
    logic [15:0] word;
    bit          running;
    int          cyc;
    vec_t        vecs[7];

    audio_i2s_tx dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: models the frame timeline and FIFO occupancy.
    always @(posedge clk) begin
        int  size_before;
        bit  frame_start;
        bit  exp_under;
        int  bit_i;
        #1;
        if (reset) begin
            q.delete();
            running = 1'b0;
            cyc     = 0;
            word    = '0;
            check_output("reset_bclk", 32'(bclk), 0);
            check_output("reset_lrclk", 32'(lrclk), 0);
            check_output("reset_sdata", 32'(sdata), 0);
            check_output("reset_underrun", 32'(underrun), 0);
            check_output("reset_level", 32'(fifo_level), 0);
            check_output("reset_ready", 32'(sample_ready), 1);
        end else begin
            size_before = q.size();
            frame_start = 1'b0;
            exp_under   = 1'b0;
            if (!running) begin
                if (size_before != 0) begin
                    running     = 1'b1;
                    cyc         = 0;
                    frame_start = 1'b1;
                end
            end else begin
                cyc++;
                if (cyc == 256) begin
                    cyc         = 0;
                    frame_start = 1'b1;
                    exp_under   = (size_before == 0);
                end
            end
            if (frame_start) word = (q.size() > 0) ? q.pop_front() : 16'h0000;
            if (sample_valid && size_before != 4) q.push_back(cur_exp);

            check_output("underrun", 32'(underrun), 32'(exp_under));
            if (!running) begin
                check_output("idle_bclk", 32'(bclk), 0);
                check_output("idle_lrclk", 32'(lrclk), 0);
                check_output("idle_sdata", 32'(sdata), 0);
            end else begin
                bit_i = cyc / 8;
                check_output("bclk", 32'(bclk), 32'((cyc % 8) >= 4));
                check_output("lrclk", 32'(lrclk), 32'(bit_i >= 16));
                check_output("sdata", 32'(sdata), 32'(word[15 - (bit_i % 16)]));
            end
            check_output("fifo_level", 32'(fifo_level), 32'(q.size()));
            check_output("sample_ready", 32'(sample_ready), 32'(q.size() != 4));
        end
    end

    // Drive one sample and hold valid until it is accepted (bounded wait).
    task automatic apply_stimulus(input logic [7:0] s, input logic [15:0] e);
        bit accepted;
        accepted     = 1'b0;
        sample_valid = 1'b1;
        sample_in    = s;
        cur_exp      = e;
        for (int n = 0; n < 2000; n++) begin
            accepted = sample_ready;
            @(negedge clk);
            if (accepted) break;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: sample %0h not accepted", s);
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 16'h7F00};
        vecs[1] = '{8'h00, 16'h8000};
        vecs[2] = '{8'h80, 16'h0000};
        vecs[3] = '{8'h3C, 16'hBC00};
        vecs[4] = '{8'hC5, 16'h4500};
        vecs[5] = '{8'h01, 16'h8100};
        vecs[6] = '{8'h7F, 16'hFF00};

        sample_in    = '0;
        sample_valid = 1'b0;
        cur_exp      = '0;
        reset        = 1'b1;
        @(negedge clk);
        do_reset();

        $display("[TB] idle with no samples");
        repeat (20) @(negedge clk);

        $display("[TB] single 0xFF then underrun frame");
        apply_stimulus(vecs[0].sample, vecs[0].slot);
        sample_valid = 1'b0;
        repeat (600) @(negedge clk);

        $display("[TB] back-to-back 0x00, 0x80");
        do_reset();
        apply_stimulus(vecs[1].sample, vecs[1].slot);
        apply_stimulus(vecs[2].sample, vecs[2].slot);
        sample_valid = 1'b0;
        repeat (800) @(negedge clk);

        $display("[TB] table vectors with valid held high");
        do_reset();
        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i].sample, vecs[i].slot);
        sample_valid = 1'b0;
        repeat (2200) @(negedge clk);

        $display("[TB] reset mid-slot");
        apply_stimulus(vecs[3].sample, vecs[3].slot);
        sample_valid = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (running && cyc == 42) break;
        end
        if (!(running && cyc == 42)) begin
            checks++;
            errors++;
            $display("[TB] FAIL midslot_wait: bit 5 never reached");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        apply_stimulus(vecs[4].sample, vecs[4].slot);
        sample_valid = 1'b0;
        repeat (300) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
